serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 176 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. Computes in_a - in_b one bit per clock,
// LSB first, through a single borrow flip-flop. An operation takes WIDTH RUN
// cycles. The result is then held in DONE until the consumer takes it.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. in_ready and out_valid are decoded from the state register only.
// No input reaches any output combinationally.
//
// Parameters:
//   WIDTH        operand / difference width, 2..32
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operands valid
//   in_ready     block can accept operands (high only in IDLE)
//   in_a, in_b   minuend / subtrahend, unsigned
//   out_valid    result valid (high only in DONE)
//   out_ready    consumer accepts result
//   out_diff     (in_a - in_b) mod 2^WIDTH
//   out_borrow   1 iff in_a < in_b
//   out_overflow signed overflow of in_a - in_b (only with SERIAL_SUB_OVF_EN)
//
// Optional feature: define SERIAL_SUB_OVF_EN to add the out_overflow port and
// its logic. The default build has neither the port nor the logic.
//
// The FSM state is held in the register 'state' (type state_t). Checkers can
// reach it by hierarchical reference.
// ----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_diff,
   output logic             out_borrow
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             out_overflow
`endif
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             bw;
   logic [CW-1:0]    cnt;

   logic             a_i;
   logic             b_i;
   logic             d_i;
   logic             bw_nxt;
   logic             accept;
   logic             last_bit;
   logic             retire;

`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb;
   logic             b_msb;
`endif

   // Full-subtractor cell applied to the current LSBs.
   assign a_i    = a_sr[0];
   assign b_i    = b_sr[0];
   assign d_i    = a_i ^ b_i ^ bw;
   assign bw_nxt = (~a_i & b_i) | (~(a_i ^ b_i) & bw);

   assign accept   = (state == IDLE) && in_valid;
   assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));
   assign retire   = (state == DONE) && out_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)   state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    if (retire)   state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   // Handshake outputs, decoded from the state register.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: operand shifters, result shifter, borrow flop, bit counter
   // and the result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr       <= '0;
         b_sr       <= '0;
         res_sr     <= '0;
         bw         <= 1'b0;
         cnt        <= '0;
         out_diff   <= '0;
         out_borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb        <= 1'b0;
         b_msb        <= 1'b0;
         out_overflow <= 1'b0;
`endif
      end else if (accept) begin
         a_sr   <= in_a;
         b_sr   <= in_b;
         res_sr <= '0;
         bw     <= 1'b0;
         cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
         // The operand registers shift away their MSBs, so keep the
         // original sign bits for the overflow decision.
         a_msb <= in_a[WIDTH-1];
         b_msb <= in_b[WIDTH-1];
`endif
      end else if (state == RUN) begin
         a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
         res_sr <= {d_i, res_sr[WIDTH-1:1]};
         bw     <= bw_nxt;
         cnt    <= cnt + CW'(1);
         if (last_bit) begin
            // Load the result including the bit computed on this edge.
            // res_sr has not taken that bit yet.
            out_diff   <= {d_i, res_sr[WIDTH-1:1]};
            out_borrow <= bw_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // d_i is the difference MSB on the final step.
            out_overflow <= (a_msb != b_msb) && (d_i != a_msb);
`endif
         end
      end else if (retire) begin
         out_diff   <= '0;
         out_borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         out_overflow <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Bench for serial_subtractor at WIDTH=8. The bench drives and samples on the
// falling clock edge. The expected results come from plain arithmetic on the
// operands. Signed overflow is judged by whether the true signed difference
// fits in WIDTH bits.
// ----------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int W = 8;

   // --- clock / reset -------------------------------------------------------
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_diff;
   logic         out_borrow;
   logic         got_ovf;

`ifdef SERIAL_SUB_OVF_EN
   logic         out_overflow;
   assign got_ovf = out_overflow;
   localparam bit OVF_EN = 1'b1;
`else
   assign got_ovf = 1'b0;
   localparam bit OVF_EN = 1'b0;
`endif

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_diff   (out_diff),
`ifdef SERIAL_SUB_OVF_EN
      .out_borrow (out_borrow),
      .out_overflow (out_overflow)
`else
      .out_borrow (out_borrow)
`endif
   );

   // --- scoreboard ----------------------------------------------------------
   int n_vec = 0;
   int n_err = 0;
   logic [W+1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference result packed as {overflow, borrow, diff}.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      int ua, ub, sa, sb, r;
      logic [W-1:0] d;
      logic borrow, ovf;
      ua = int'(a);
      ub = int'(b);
      sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
      sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
      r = sa - sb;
      d = W'((ua - ub + (1 << W)) % (1 << W));
      borrow = (ua < ub);
      ovf = OVF_EN && ((r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1))));
      return {ovf, borrow, d};
   endfunction

   function automatic logic [63:0] got_res();
      return 64'({got_ovf, out_borrow, out_diff});
   endfunction

   // --- driver tasks --------------------------------------------------------
   // One complete operation from IDLE. It checks the latency, the result,
   // stability under 'hold' cycles of backpressure, and the return to IDLE.
   // With 'noise' set, it pulses in_valid with junk operands while busy.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_diff, input logic exp_borrow,
                         input logic exp_ovf, input int hold, input bit noise);
      int lat;
      check("ready_idle", 64'(in_ready), 64'(1));
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      in_a = W'($urandom);
      in_b = W'($urandom);
      check("ready_run", 64'(in_ready), 64'(0));
      lat = 0;
      while (!out_valid && lat < 64) begin
         if (noise) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a = W'($urandom);
            in_b = W'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), 64'(W));
      check("diff", 64'(out_diff), 64'(exp_diff));
      check("borrow", 64'(out_borrow), 64'(exp_borrow));
      if (OVF_EN) check("overflow", 64'(got_ovf), 64'(exp_ovf));
      check("model", got_res(), 64'(model(a, b)));
      for (int i = 0; i < hold; i++) begin
         if (noise) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a = W'($urandom);
            in_b = W'($urandom);
         end
         @(negedge clk);
         check("hold_valid", 64'(out_valid), 64'(1));
         check("hold_diff", 64'(out_diff), 64'(exp_diff));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("retire_valid", 64'(out_valid), 64'(0));
      check("retire_ready", 64'(in_ready), 64'(1));
      check("retire_clear", 64'({out_borrow, out_diff}), 64'(0));
   endtask

   // Back-to-back stream: in_valid held high, random out_ready.
   task automatic stream(input int count);
      int sent, got, cyc;
      bit acc;
      logic [W+1:0] e;
      sent = 0;
      got = 0;
      cyc = 0;
      in_a = W'($urandom);
      in_b = W'($urandom);
      in_valid = 1'b1;
      while ((sent < count || exp_q.size() > 0) && cyc < 5000) begin
         out_ready = 1'($urandom_range(0, 1));
         acc = in_valid && in_ready;
         if (acc) begin
            exp_q.push_back(model(in_a, in_b));
            sent++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("b2b_dup", 64'(1), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("b2b_res", got_res(), 64'(e));
               got++;
            end
         end
         @(negedge clk);
         cyc++;
         if (acc) begin
            if (sent < count) begin
               in_a = W'($urandom);
               in_b = W'($urandom);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("b2b_timeout", 64'(cyc < 5000), 64'(1));
      check("b2b_count", 64'(got), 64'(count));
   endtask

   // --- main sequence -------------------------------------------------------
   initial begin
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(in_ready), 64'(1));
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_res", got_res(), 64'(0));
      rst_n = 1'b1;

      run_op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 0, 1'b0);
      run_op(8'h12, 8'h35, 8'hDD, 1'b1, 1'b0, 0, 1'b0);
      run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
      run_op(8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0, 0, 1'b0);
      run_op(8'hF0, 8'h0F, 8'hE1, 1'b0, 1'b0, 5, 1'b1);

      // No phantom operation after the noisy run.
      repeat (W + 2) @(negedge clk);
      check("idle_quiet", 64'({out_valid, in_ready}), 64'(1));

      // Abort with reset in the third RUN cycle.
      in_a = 8'h80;
      in_b = 8'h01;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_ready", 64'(in_ready), 64'(1));
      check("abort_valid", 64'(out_valid), 64'(0));
      check("abort_res", got_res(), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0, 1'b0);

      // Signed overflow corners (the overflow check runs only when enabled).
      run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, 1'b0);
      run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0, 1'b0);
      run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 0, 1'b0);

      stream(50);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
